// File: rtl/vote_key_decoder_if.sv
// Bundle of ballot-control inputs and vote-result outputs for the voting-machine key decoder.
// The master drives the operator/key inputs and the slave is the decoder itself.
interface vote_key_decoder_if;
   logic       Power;
   logic       Close;
   logic       Ballot;
   logic [3:0] IN;
   logic       armed;
   logic       vote_valid;
   logic [1:0] vote_cand;
   logic       spoilt;
   logic       timeout;

   modport master (
      output Power, Close, Ballot, IN,
      input  armed, vote_valid, vote_cand, spoilt, timeout
   );

   modport slave (
      input  Power, Close, Ballot, IN,
      output armed, vote_valid, vote_cand, spoilt, timeout
   );
endinterface

// File: rtl/vote_key_decoder.sv
// Candidate-key decoder for an electronic voting unit: arms on a presiding-officer key edge,
// debounces the candidate keys and emits exactly one vote, spoil or timeout event per ballot.
module vote_key_decoder #(
   parameter int DEB  = 2,
   parameter int TOUT = 255
) (
   input  logic              clk,
   input  logic              Reset,
   vote_key_decoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CLEAN, ARMED, WAIT_REL} state_t;

   state_t     state;
   logic [2:0] deb_cnt;
   logic [7:0] tout_cnt;
   logic [3:0] prev_in;
   logic       ballot_d;

   logic       key_any;
   logic       stable;
   logic       one_hot;
   logic       accept;
   logic       tout_hit;
   logic [2:0] deb_next;
   logic [7:0] tout_next;
   logic [1:0] cand_enc;

   // A held pattern only counts toward acceptance while it repeats unchanged.
   always_comb begin
      key_any   = |bus.IN;
      stable    = key_any && (bus.IN == prev_in);
      deb_next  = stable ? (deb_cnt + 3'd1) : {2'b00, key_any};
      accept    = (deb_next == 3'(DEB));
      one_hot   = key_any && ((bus.IN & (bus.IN - 4'd1)) == 4'd0);
      tout_next = tout_cnt + 8'd1;
      tout_hit  = !key_any && (tout_next == 8'(TOUT));
      case (bus.IN)
         4'b0010: cand_enc = 2'd1;
         4'b0100: cand_enc = 2'd2;
         4'b1000: cand_enc = 2'd3;
         default: cand_enc = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state          <= IDLE;
         deb_cnt        <= 3'd0;
         tout_cnt       <= 8'd0;
         prev_in        <= 4'd0;
         ballot_d       <= 1'b0;
         bus.armed      <= 1'b0;
         bus.vote_valid <= 1'b0;
         bus.vote_cand  <= 2'd0;
         bus.spoilt     <= 1'b0;
         bus.timeout    <= 1'b0;
      end else begin
         ballot_d       <= bus.Ballot;
         prev_in        <= bus.IN;
         bus.vote_valid <= 1'b0;
         bus.vote_cand  <= 2'd0;
         bus.spoilt     <= 1'b0;
         bus.timeout    <= 1'b0;
         // Losing power or closing the election silently drops any ballot in progress.
         if (!bus.Power || bus.Close) begin
            state     <= IDLE;
            bus.armed <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.Ballot && !ballot_d) begin
                     state     <= CLEAN;
                     bus.armed <= 1'b1;
                  end
               end
               CLEAN: begin
                  if (!key_any) begin
                     state    <= ARMED;
                     deb_cnt  <= 3'd0;
                     tout_cnt <= 8'd0;
                  end
               end
               ARMED: begin
                  deb_cnt <= deb_next;
                  if (accept) begin
                     state     <= WAIT_REL;
                     bus.armed <= 1'b0;
                     if (one_hot) begin
                        bus.vote_valid <= 1'b1;
                        bus.vote_cand  <= cand_enc;
                     end else begin
                        bus.spoilt <= 1'b1;
                     end
                  end else if (!key_any) begin
                     tout_cnt <= tout_next;
                     if (tout_hit) begin
                        state       <= IDLE;
                        bus.armed   <= 1'b0;
                        bus.timeout <= 1'b1;
                     end
                  end
               end
               WAIT_REL: begin
                  if (!key_any) state <= IDLE;
               end
               default: begin
                  state     <= IDLE;
                  bus.armed <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vote_key_decoder.sv
// Table-driven bench for vote_key_decoder (DEB=2, TOUT=8): every vector queues its expected
// outputs, which are popped and compared one clock after the inputs are applied.
module tb_vote_key_decoder;

   typedef struct {
      string      name;
      logic       rst;
      logic       pw;
      logic       cl;
      logic       bal;
      logic [3:0] keys;
      logic [5:0] exp;
   } vec_t;

   logic clk;
   logic reset;
   int   applied;
   int   miscompares;

   vec_t       vecs[$];
   logic [5:0] sb_q[$];

   vote_key_decoder_if vif ();

   vote_key_decoder #(.DEB(2), .TOUT(8)) dut (
      .clk   (clk),
      .Reset (reset),
      .bus   (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string n, input logic r, p, c, b, input logic [3:0] k,
                               input logic a, vv, input logic [1:0] cd, input logic sp, to);
      vec_t v;
      v.name = n;
      v.rst  = r;
      v.pw   = p;
      v.cl   = c;
      v.bal  = b;
      v.keys = k;
      v.exp  = {a, vv, cd, sp, to};
      return v;
   endfunction

   task automatic add(input string n, input logic r, p, c, b, input logic [3:0] k,
                      input logic a, vv, input logic [1:0] cd, input logic sp, to);
      vecs.push_back(mk(n, r, p, c, b, k, a, vv, cd, sp, to));
   endtask

   task automatic checkOutput(input string n);
      logic [5:0] act;
      logic [5:0] expv;
      expv = sb_q.pop_front();
      act  = {vif.armed, vif.vote_valid, vif.vote_cand, vif.spoilt, vif.timeout};
      applied++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s vec#%0d: armed/vv/cand/spoilt/timeout got %b required %b",
                  n, applied, act, expv);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset      = v.rst;
      vif.Power  = v.pw;
      vif.Close  = v.cl;
      vif.Ballot = v.bal;
      vif.IN     = v.keys;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
      checkOutput(v.name);
   endtask

   initial begin
      applied     = 0;
      miscompares = 0;
      reset       = 1'b1;
      vif.Power   = 1'b1;
      vif.Close   = 1'b0;
      vif.Ballot  = 1'b0;
      vif.IN      = 4'd0;

      //   name        rst pw cl bal keys    arm vv cand sp to
      add("reset",      1, 0, 1, 1, 4'hF,    0, 0, 2'd0, 0, 0);
      add("reset",      1, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("basic",      0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("basic",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("basic",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("basic",      0, 1, 0, 1, 4'h2,    1, 0, 2'd0, 0, 0);
      add("basic",      0, 1, 0, 1, 4'h2,    0, 1, 2'd1, 0, 0);
      add("basic",      0, 1, 0, 1, 4'h2,    0, 0, 2'd0, 0, 0);
      add("basic",      0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("multikey",   0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("multikey",   0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("multikey",   0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("multikey",   0, 1, 0, 1, 4'h5,    1, 0, 2'd0, 0, 0);
      add("multikey",   0, 1, 0, 1, 4'h5,    0, 0, 2'd0, 1, 0);
      add("multikey",   0, 1, 0, 1, 4'h5,    0, 0, 2'd0, 0, 0);
      add("rearm_wait", 0, 1, 0, 0, 4'h5,    0, 0, 2'd0, 0, 0);
      add("rearm_wait", 0, 1, 0, 1, 4'h5,    0, 0, 2'd0, 0, 0);
      add("rearm_wait", 0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("rearm",      0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("rearm",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("rearm",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("glitch",     0, 1, 0, 1, 4'h8,    1, 0, 2'd0, 0, 0);
      add("glitch",     0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("glitch",     0, 1, 0, 1, 4'h4,    1, 0, 2'd0, 0, 0);
      add("glitch",     0, 1, 0, 1, 4'h4,    0, 1, 2'd2, 0, 0);
      add("glitch",     0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 0, 4'h1,    0, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h1,    1, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h1,    1, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h1,    1, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h1,    1, 0, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h1,    0, 1, 2'd0, 0, 0);
      add("heldkey",    0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("timeout",    0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("timeout",    0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("timeout",    0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      for (int i = 0; i < 7; i++)
         add("timeout",  0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("timeout",    0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 1);
      add("timeout",    0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("close",      0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("close",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("close",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("close",      0, 1, 0, 1, 4'h4,    1, 0, 2'd0, 0, 0);
      add("close",      0, 1, 1, 1, 4'h4,    0, 0, 2'd0, 0, 0);
      add("close",      0, 1, 1, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("close",      0, 1, 1, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("close",      0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("power",      0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("power",      0, 0, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("power",      0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("power",      0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("power",      0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("power",      0, 0, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("power",      0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);
      add("restart",    0, 1, 0, 0, 4'h0,    0, 0, 2'd0, 0, 0);
      add("restart",    0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("restart",    0, 1, 0, 1, 4'h0,    1, 0, 2'd0, 0, 0);
      add("restart",    0, 1, 0, 1, 4'h1,    1, 0, 2'd0, 0, 0);
      add("restart",    0, 1, 0, 1, 4'h3,    1, 0, 2'd0, 0, 0);
      add("restart",    0, 1, 0, 1, 4'h3,    0, 0, 2'd0, 1, 0);
      add("restart",    0, 1, 0, 1, 4'h0,    0, 0, 2'd0, 0, 0);

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i]);

      // Every candidate key in turn, checking the encoded index.
      for (int c = 0; c < 4; c++) begin
         logic [3:0] key;
         key = 4'b0001 << c;
         applyStimulus(mk("cand", 0, 1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0));
         applyStimulus(mk("cand", 0, 1, 0, 1, 4'h0, 1, 0, 2'd0, 0, 0));
         applyStimulus(mk("cand", 0, 1, 0, 1, 4'h0, 1, 0, 2'd0, 0, 0));
         applyStimulus(mk("cand", 0, 1, 0, 1, key,  1, 0, 2'd0, 0, 0));
         applyStimulus(mk("cand", 0, 1, 0, 1, key,  0, 1, 2'(c), 0, 0));
         applyStimulus(mk("cand", 0, 1, 0, 1, 4'h0, 0, 0, 2'd0, 0, 0));
      end

      // Reset in the middle of a debounce drops the ballot with no pulse.
      applyStimulus(mk("rst_deb", 0, 1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_deb", 0, 1, 0, 1, 4'h0, 1, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_deb", 0, 1, 0, 1, 4'h0, 1, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_deb", 0, 1, 0, 1, 4'h2, 1, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_deb", 1, 1, 0, 0, 4'h2, 0, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_deb", 0, 1, 0, 0, 4'h2, 0, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_deb", 0, 1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0));

      // Reset while waiting for release, then a clean release stays idle.
      applyStimulus(mk("rst_wait", 0, 1, 0, 1, 4'h0, 1, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_wait", 0, 1, 0, 1, 4'h0, 1, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_wait", 0, 1, 0, 1, 4'h1, 1, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_wait", 0, 1, 0, 1, 4'h1, 0, 1, 2'd0, 0, 0));
      applyStimulus(mk("rst_wait", 1, 1, 0, 0, 4'h1, 0, 0, 2'd0, 0, 0));
      applyStimulus(mk("rst_wait", 0, 1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/vote_key_decoder.md
VOTE_KEY_DECODER -- requirements
Module: vote_key_decoder

Interface
REQ-001 Parameters SHALL be: DEB, default 2, number of consecutive identical key samples needed to accept a key pattern (legal range 1..7); TOUT, default 255, ARMED-state timeout in cycles (legal range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  reset, synchronous and active-high.
REQ-004 Power  in  1  machine powered; when low, the block is held idle.
REQ-005 Close  in  1  election closed; when high, ballots are refused.
REQ-006 Ballot  in  1  presiding-officer arm key, level input; only its rising edge is used.
REQ-007 IN  in  4  raw candidate keys, one bit per candidate (bit0 = candidate 0).
REQ-008 armed  out  1  high while a ballot is issued and no vote has been cast yet.
REQ-009 vote_valid  out  1  one-cycle pulse: one accepted vote.
REQ-010 vote_cand  out  2  encoded candidate index, valid only while vote_valid is high, otherwise 0.
REQ-011 spoilt  out  1  one-cycle pulse: ballot consumed by a multi-key press.
REQ-012 timeout  out  1  one-cycle pulse: armed ballot expired with no key press.

Function
REQ-013 State machine SHALL have four states:
- IDLE: no ballot.
- CLEAN: armed, waiting for all keys released.
- ARMED: armed, keys released, counting debounce.
- WAIT_REL: ballot consumed, waiting for keys released.
REQ-014 All outputs SHALL be registered.
REQ-015 Ballot edge detection SHALL use a one-cycle delayed copy of Ballot.
REQ-016 IDLE -> CLEAN on a Ballot rising edge, only when Power=1 and Close=0.
REQ-017 Ballot edges in any state other than IDLE SHALL be ignored; no re-arm and no counter reset.
REQ-018 CLEAN -> ARMED on the first sampled IN=0000. A key already held at arm time therefore never votes.
REQ-019 In ARMED, a sample is "stable" when IN is nonzero and equals the previous sample.
- Stable sample: increment the debounce count.
- Any other sample: reload the count to 1 if IN is nonzero, or 0 if IN is zero.
REQ-020 When the debounce count reaches DEB with a one-hot pattern, the block SHALL pulse vote_valid with vote_cand set to the index of the set bit, then go to WAIT_REL.
- Latency: the pulse appears in the cycle after the DEB-th identical sample.
REQ-021 When the debounce count reaches DEB with two or more bits set, the block SHALL pulse spoilt, with no vote_valid, then go to WAIT_REL.
REQ-022 A nonzero pattern held for fewer than DEB samples SHALL be discarded; the block stays ARMED.
REQ-023 A pattern change mid-debounce (e.g. 0001 -> 0011) SHALL restart the count on the new pattern.
REQ-024 Timeout counter (8-bit):
- Cleared on entry to ARMED.
- Increments every ARMED cycle in which IN=0000.
- Held (not cleared) while a key is nonzero.
- On reaching TOUT: pulse timeout and go to IDLE.
REQ-025 If the timeout and a debounce acceptance fall in the same cycle, the vote or spoil SHALL take priority and no timeout pulse is produced.
REQ-026 WAIT_REL -> IDLE on the first sampled IN=0000.
REQ-027 armed SHALL be 1 exactly when the state is CLEAN or ARMED.
REQ-028 Power=0 or Close=1 in any state SHALL force IDLE on the next edge.
- No pulses in that cycle; an armed ballot is dropped silently.
- Power/Close has priority over every other transition, including a same-cycle acceptance.
REQ-029 At most one of vote_valid, spoilt, timeout SHALL be high in any cycle, and each SHALL be high for exactly one cycle per event.

Reset
REQ-030 Reset=1 at a rising edge SHALL set, regardless of Power or Close:
- State to IDLE.
- Debounce count, timeout count, previous-IN register and Ballot delay register to 0.
- armed, vote_valid, vote_cand, spoilt and timeout to 0.
REQ-031 Reset asserted mid-debounce or in WAIT_REL SHALL discard the ballot without any pulse.
REQ-032 Reset SHALL take priority over all other inputs.

Verification
REQ-033 Basic vote: Power=1, Close=0, DEB=2; Ballot 0->1; IN=0000 for 1 cycle, then 0010 for 2 cycles -> armed=1 from the edge after arming, exactly one vote_valid with vote_cand=1 the cycle after the 2nd sample, armed=0 afterwards; IN=0000 -> IDLE.
REQ-034 Multi-key: arm; IN=0101 held for 3 cycles -> exactly one spoilt pulse, no vote_valid; a second Ballot edge during WAIT_REL is ignored; after release, a new Ballot edge re-arms.
REQ-035 Glitch and held key:
- IN=0001 held before Ballot rises -> armed=1 but no vote until IN returns to 0000 and 0001 is pressed again for DEB cycles.
- A 1-cycle 1000 glitch produces no output.
REQ-036 Timeout: TOUT=8; arm, keep IN=0000 -> timeout pulse in the cycle after the 8th ARMED idle cycle, then IDLE, armed=0.
REQ-037 Close/Power/Reset: Close=1 during ARMED with IN=0100 stable on the same edge -> no vote_valid, IDLE. Ballot edge while Close=1 -> no arming. Reset=1 mid-debounce -> all outputs 0 the next cycle.
